// File: rtl/obj_scan_scheduler.sv
// Per-scanline OBJ scan controller: walks attributes 0..31 and queues covering objects.
// Optional build macro OBJ_SCAN_DOUBLE_SIZE_EN doubles the height of rot/scale double-size objects.
module obj_scan_scheduler #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        line_start,
    input  logic [7:0]  vcount,
    output logic [4:0]  attr_no,
    output logic        start,
    input  logic        done,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        obj_valid,
    output logic [4:0]  obj_no,
    input  logic        obj_ready,
    output logic        scan_busy,
    output logic        scan_done,
    output logic        overflow
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [7:0]      line_q, line_d;
    logic [4:0]      idx_q, idx_d;
    logic            overflow_q, overflow_d;
    logic            pending_q, pending_d;

    logic [4:0]      mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic            push, pop, room, fifo_clear;

    logic [1:0]      shape, size;
    logic            disabled;
    logic [8:0]      height;
    logic [7:0]      diff;
    logic            hit;
    logic            unused_attr_bits;

    assign unused_attr_bits = ^{A[13:10], B[13:0]};

    // Object height lookup and line coverage test.
    always_comb begin
        shape    = A[15:14];
        size     = B[15:14];
        disabled = !A[8] && A[9];
        height   = 9'd0;
        unique case ({shape, size})
            4'b00_00: height = 9'd8;
            4'b00_01: height = 9'd16;
            4'b00_10: height = 9'd32;
            4'b00_11: height = 9'd64;
            4'b01_00: height = 9'd8;
            4'b01_01: height = 9'd8;
            4'b01_10: height = 9'd16;
            4'b01_11: height = 9'd32;
            4'b10_00: height = 9'd16;
            4'b10_01: height = 9'd32;
            4'b10_10: height = 9'd32;
            4'b10_11: height = 9'd64;
            default:  height = 9'd0;
        endcase
`ifdef OBJ_SCAN_DOUBLE_SIZE_EN
        if (A[8] && A[9]) begin
            height = height << 1;
        end
`endif
        diff = line_q - A[7:0];
        hit  = !disabled && (shape != 2'd3) && ({1'b0, diff} < height);
    end

    assign obj_valid = (count_q != '0);
    assign pop       = obj_valid && obj_ready;
    assign room      = (count_q < CntW'(DEPTH)) || pop;

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;
        pending_d  = pending_q;
        push       = 1'b0;
        fifo_clear = 1'b0;
        start      = 1'b0;
        if (done) begin
            pending_d = 1'b0;
        end
        unique case (state_q)
            StIdle, StDone: begin
                if (line_start) begin
                    line_d     = vcount;
                    idx_d      = 5'd0;
                    fifo_clear = 1'b1;
                    overflow_d = 1'b0;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                start     = 1'b1;
                pending_d = 1'b1;
                if (line_start) begin
                    line_d  = vcount;
                    state_d = StDrain;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // A done coinciding with an abort is dropped; pending_d already clears.
                if (line_start) begin
                    line_d  = vcount;
                    state_d = StDrain;
                end else if (done) begin
                    if (hit && !room) begin
                        overflow_d = 1'b1;
                        state_d    = StDone;
                    end else begin
                        push = hit;
                        if (idx_q == 5'd31) begin
                            state_d = StDone;
                        end else begin
                            idx_d   = idx_q + 5'd1;
                            state_d = StIssue;
                        end
                    end
                end
            end
            StDrain: begin
                if (line_start) begin
                    line_d = vcount;
                end
                if (done || !pending_q) begin
                    idx_d      = 5'd0;
                    fifo_clear = 1'b1;
                    overflow_d = 1'b0;
                    state_d    = StIssue;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            line_q     <= 8'd0;
            idx_q      <= 5'd0;
            overflow_q <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            pending_q  <= pending_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (fifo_clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= idx_q;
        end
    end

    assign obj_no    = obj_valid ? mem_q[rd_ptr_q] : 5'd0;
    assign attr_no   = idx_q;
    assign scan_busy = (state_q == StIssue) || (state_q == StWait) || (state_q == StDrain);
    assign scan_done = (state_q == StDone);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_obj_scan_scheduler.sv
// Self-checking bench for obj_scan_scheduler with a 5-cycle attribute lookup responder.
module tb_obj_scan_scheduler;

    localparam int unsigned DEPTH = 8;
    localparam int HT [3][4] = '{'{8, 16, 32, 64}, '{8, 8, 16, 32}, '{16, 32, 32, 64}};

    logic        clock, reset, line_start, done, obj_ready;
    logic [7:0]  vcount;
    logic [4:0]  attr_no, obj_no;
    logic        start, obj_valid, scan_busy, scan_done, overflow;
    logic [15:0] A, B;

    logic [15:0] tbl_a [32];
    logic [15:0] tbl_b [32];
    int          n_checks, n_pass, n_fail, n_starts, cyc;
    int          exp_q[$];
    bit          exp_ovf;
    int          exp_starts;

    obj_scan_scheduler #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .line_start (line_start),
        .vcount     (vcount),
        .attr_no    (attr_no),
        .start      (start),
        .done       (done),
        .A          (A),
        .B          (B),
        .obj_valid  (obj_valid),
        .obj_no     (obj_no),
        .obj_ready  (obj_ready),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done),
        .overflow   (overflow)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Lookup unit: done (with table data) five cycles after each start.
    initial begin : lookup
        logic [4:0] no;
        done = 0; A = '0; B = '0; n_starts = 0;
        forever begin
            @(negedge clock);
            if (start === 1'b1) begin
                no = attr_no;
                n_starts++;
                repeat (5) @(posedge clock);
                #1; done = 1; A = tbl_a[no]; B = tbl_b[no];
                @(posedge clock);
                #1; done = 0; A = 16'($urandom); B = 16'($urandom);
            end
        end
    end

    function automatic bit covers(input logic [15:0] a, input logic [15:0] b, input logic [7:0] v);
        int shp, h, d;
        shp = int'(a[15:14]);
        if (!a[8] && a[9]) return 0;
        if (shp == 3) return 0;
        h = HT[shp][int'(b[15:14])];
`ifdef OBJ_SCAN_DOUBLE_SIZE_EN
        if (a[8] && a[9]) h = 2 * h;
`endif
        d = (int'(v) - int'(a[7:0]) + 256) % 256;
        return d < h;
    endfunction

    task automatic model_scan(input logic [7:0] v);
        exp_q = {};
        exp_ovf = 0;
        exp_starts = 32;
        for (int i = 0; i < 32; i++) begin
            if (covers(tbl_a[i], tbl_b[i], v)) begin
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back(i);
                end else begin
                    exp_ovf = 1;
                    exp_starts = i + 1;
                    break;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic disable_all();
        for (int i = 0; i < 32; i++) begin
            tbl_a[i] = 16'h0200;
            tbl_b[i] = 16'h0000;
        end
    endtask

    task automatic pulse_line(input logic [7:0] v);
        @(posedge clock); #1; line_start = 1; vcount = v;
        @(posedge clock); #1; line_start = 0; vcount = 8'($urandom);
    endtask

    task automatic wait_start(input string tag, input int want, output int t);
        int k;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!(start === 1'b1 && (want < 0 || int'(attr_no) == want)) && k < 500);
        check({tag, " start seen"}, start, 1);
        t = cyc;
    endtask

    task automatic wait_scan_done(input string tag, output int t);
        int k;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (scan_done !== 1'b1 && k < 1000);
        check({tag, " scan_done"}, scan_done, 1);
        t = cyc;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 200) begin
            @(negedge clock);
            k++;
            if (obj_valid === 1'b1) begin
                check({tag, " obj_no"}, obj_no, exp_q.pop_front());
                obj_ready = 1;
            end else begin
                obj_ready = 0;
            end
        end
        check({tag, " entries left"}, exp_q.size(), 0);
        @(posedge clock); #1; obj_ready = 0;
        @(negedge clock);
        check({tag, " fifo empty"}, obj_valid, 0);
    endtask

    task automatic run_scan(input string tag, input logic [7:0] v);
        int s0, t0, t1;
        model_scan(v);
        s0 = n_starts;
        pulse_line(v);
        wait_start(tag, -1, t0);
        check({tag, " first attr_no"}, attr_no, 0);
        check({tag, " busy"}, scan_busy, 1);
        wait_scan_done(tag, t1);
        check({tag, " scan cycles"}, t1 - t0, 6 * exp_starts);
        check({tag, " overflow"}, overflow, exp_ovf);
        check({tag, " starts"}, n_starts - s0, exp_starts);
        drain(tag);
    endtask

    initial begin
        int t0, t1, t5, tn, s0;
        logic [7:0] v;
        n_checks = 0; n_pass = 0; n_fail = 0;
        reset = 1; line_start = 0; vcount = 0; obj_ready = 0;
        disable_all();
        repeat (3) @(posedge clock);
        #1; reset = 0;
        @(negedge clock);
        check("reset start", start, 0);
        check("reset attr_no", attr_no, 0);
        check("reset obj_valid", obj_valid, 0);
        check("reset obj_no", obj_no, 0);
        check("reset scan_busy", scan_busy, 0);
        check("reset scan_done", scan_done, 0);
        check("reset overflow", overflow, 0);

        disable_all();
        tbl_a[3] = {2'd0, 6'd0, 8'd16};
        run_scan("basic", 8'd20);

        disable_all();
        tbl_a[0] = {2'd2, 6'd0, 8'd250};
        tbl_b[0] = {2'd1, 14'd0};
        run_scan("wrap_hit", 8'd4);
        run_scan("wrap_miss", 8'd26);

        disable_all();
        tbl_a[1] = {2'd0, 4'd0, 2'b11, 8'd0};
        tbl_b[1] = {2'd3, 14'd0};
        run_scan("double", 8'd100);

        for (int i = 0; i < 32; i++) begin
            tbl_a[i] = {2'd0, 6'd0, 8'd50};
            tbl_b[i] = 16'h0000;
        end
        run_scan("overflow", 8'd50);

        // FIFO full when obj 8 hits, with a pop in that same cycle.
        disable_all();
        for (int i = 0; i <= 8; i++) tbl_a[i] = {2'd0, 6'd0, 8'd60};
        s0 = n_starts;
        pulse_line(8'd60);
        wait_start("pushpop", 8, t0);
        repeat (5) @(posedge clock);
        #1; obj_ready = 1;
        @(posedge clock);
        #1; obj_ready = 0;
        wait_scan_done("pushpop", t1);
        check("pushpop overflow", overflow, 0);
        check("pushpop starts", n_starts - s0, 32);
        exp_q = {};
        for (int i = 1; i <= 8; i++) exp_q.push_back(i);
        drain("pushpop");

        // Abort two cycles after obj 5's start.
        disable_all();
        tbl_a[2] = {2'd0, 6'd0, 8'd30};
        tbl_a[7] = {2'd0, 6'd0, 8'd200};
        pulse_line(8'd32);
        wait_start("abort", 5, t5);
        check("abort pre fifo valid", obj_valid, 1);
        @(posedge clock);
        @(posedge clock);
        #1; line_start = 1; vcount = 8'd205;
        @(posedge clock);
        #1; line_start = 0; vcount = 8'd0;
        model_scan(8'd205);
        s0 = n_starts;
        wait_start("abort restart", -1, tn);
        check("abort restart delay", tn - t5, 6);
        check("abort restart attr_no", attr_no, 0);
        check("abort fifo cleared", obj_valid, 0);
        wait_scan_done("abort", t1);
        check("abort scan cycles", t1 - tn, 6 * exp_starts);
        check("abort overflow", overflow, exp_ovf);
        drain("abort");

        for (int r = 0; r < 6; r++) begin
            v = 8'($urandom);
            for (int i = 0; i < 32; i++) begin
                tbl_a[i] = 16'($urandom);
                tbl_a[i][7:0] = v - 8'($urandom_range(0, 70));
                tbl_b[i] = 16'($urandom);
            end
            run_scan($sformatf("rand%0d", r), v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
